// File: rtl/lane_unstripe_sched_if.sv
// Bundle of the lane data inputs, control inputs and merged-stream outputs
// of the four-lane un-striping scheduler.
// There is no per-transfer backpressure: a lane byte is offered when its
// valid bit is 1 and is taken or dropped on that same edge. Merged bytes are
// presented on out whenever validout is 1, and the sink must take every one.
interface lane_unstripe_sched_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] in0;
  logic [DATA_W-1:0] in1;
  logic [DATA_W-1:0] in2;
  logic [DATA_W-1:0] in3;
  logic [3:0]        valid;
  logic [1:0]        lanes_active;
  logic              enable;
  logic [DATA_W-1:0] out;
  logic              validout;
  logic [3:0]        pop;
  logic [3:0]        full;
  logic [3:0]        overflow;
  logic              idle;
  logic              dbg_state;

  modport slave (
    input  in0, in1, in2, in3, valid, lanes_active, enable,
    output out, validout, pop, full, overflow, idle, dbg_state
  );

  modport master (
    output in0, in1, in2, in3, valid, lanes_active, enable,
    input  out, validout, pop, full, overflow, idle, dbg_state
  );
endinterface

// File: rtl/lane_unstripe_sched.sv
// Reassembles a byte stream striped over up to four lanes. Each lane has a
// small FIFO, and lanes are drained in strict round-robin order so byte order
// survives lane skew and stalls. dbg_state exposes the FSM (0=IDLE, 1=RUN).
module lane_unstripe_sched #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                  clk4f,
  input  logic                  reset,
  lane_unstripe_sched_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t            r_state, w_state_nxt;
  logic [2:0]        r_n, w_n_cfg;
  logic [1:0]        r_ptr, w_ptr_nxt;
  logic [CW-1:0]     r_cnt [4];
  logic [AW-1:0]     r_wp  [4];
  logic [AW-1:0]     r_rp  [4];
  logic [DATA_W-1:0] r_mem [4][DEPTH];
  logic [DATA_W-1:0] w_din [4];
  logic [3:0]        w_active, w_push, w_drop, w_pop, w_full, w_empty;
  logic              w_pop_en;
  logic [DATA_W-1:0] w_head;
  logic [DATA_W-1:0] r_out;
  logic              r_validout;
  logic [3:0]        r_pop, r_overflow;

  assign w_din[0] = bus.in0;
  assign w_din[1] = bus.in1;
  assign w_din[2] = bus.in2;
  assign w_din[3] = bus.in3;

  // Lane count requested by lanes_active; only taken on entry to RUN.
  assign w_n_cfg = (bus.lanes_active == 2'd0) ? 3'd1 :
                   (bus.lanes_active == 2'd1) ? 3'd2 : 3'd4;

  assign w_head = r_mem[r_ptr][r_rp[r_ptr]];

  // Per-lane status; full is judged on the registered count only.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      w_active[i] = (3'(i) < r_n);
      w_full[i]   = (r_cnt[i] == FULL_CNT);
      w_empty[i]  = (r_cnt[i] == '0);
      w_push[i]   = w_active[i] & bus.valid[i] & ~w_full[i];
      w_drop[i]   = w_active[i] & bus.valid[i] & w_full[i];
    end
  end

  // Next state, round-robin pointer and pop decision.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_pop_en    = 1'b0;
    w_pop       = '0;
    unique case (r_state)
      S_IDLE: begin
        if (bus.enable) begin
          w_state_nxt = S_RUN;
          // A shrunk lane count must not leave ptr on a dead lane.
          if ({1'b0, r_ptr} >= w_n_cfg) w_ptr_nxt = '0;
        end
      end
      S_RUN: begin
        if (!bus.enable) begin
          w_state_nxt = S_IDLE;
        end else if (!w_empty[r_ptr]) begin
          // Strict order: an empty lane stalls the stream, never skipped.
          w_pop_en       = 1'b1;
          w_pop[r_ptr]   = 1'b1;
          w_ptr_nxt      = (({1'b0, r_ptr} + 3'd1) == r_n) ? 2'd0 : r_ptr + 2'd1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM state, pointer and latched lane count.
  always_ff @(posedge clk4f) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_n     <= 3'd4;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      if ((r_state == S_IDLE) && bus.enable) r_n <= w_n_cfg;
    end
  end

  // FIFO counts and read/write pointers; reset flushes every lane.
  always_ff @(posedge clk4f) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        r_cnt[i] <= '0;
        r_wp[i]  <= '0;
        r_rp[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (w_push[i]) r_wp[i] <= r_wp[i] + AW'(1);
        if (w_pop[i])  r_rp[i] <= r_rp[i] + AW'(1);
        if (w_push[i] && !w_pop[i])      r_cnt[i] <= r_cnt[i] + CW'(1);
        else if (!w_push[i] && w_pop[i]) r_cnt[i] <= r_cnt[i] - CW'(1);
      end
    end
  end

  // FIFO storage; contents are don't-care until written.
  always_ff @(posedge clk4f) begin
    for (int i = 0; i < 4; i++) begin
      if (w_push[i]) r_mem[i][r_wp[i]] <= w_din[i];
    end
  end

  // Registered merged output; out holds its value between valid bytes.
  always_ff @(posedge clk4f) begin
    if (reset) begin
      r_out      <= '0;
      r_validout <= 1'b0;
      r_pop      <= '0;
      r_overflow <= '0;
    end else begin
      r_validout <= w_pop_en;
      r_pop      <= w_pop;
      if (w_pop_en) r_out <= w_head;
      r_overflow <= r_overflow | w_drop;
    end
  end

  assign bus.out       = r_out;
  assign bus.validout  = r_validout;
  assign bus.pop       = r_pop;
  assign bus.full      = w_full;
  assign bus.overflow  = r_overflow;
  assign bus.idle      = (r_state == S_IDLE) && ((w_empty | ~w_active) == 4'hF);
  assign bus.dbg_state = r_state;
endmodule

// File: tb/tb_lane_unstripe_sched.sv
// Directed bench for lane_unstripe_sched: in-order merge, lane skew, x2 mode,
// overflow, pause/reconfigure and reset flush.
module tb_lane_unstripe_sched;
  logic clk4f;
  logic reset;
  int   n_tests;
  int   n_fail;

  lane_unstripe_sched_if #(.DATA_W(8)) bus ();

  lane_unstripe_sched #(.DATA_W(8), .DEPTH(4)) dut (
    .clk4f (clk4f),
    .reset (reset),
    .bus   (bus)
  );

  // Clock and reset
  initial clk4f = 1'b0;
  always #5 clk4f = ~clk4f;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  // Driver tasks
  task automatic step();
    @(posedge clk4f);
    #1;
  endtask

  task automatic drive(input logic [3:0] v, input logic [7:0] d0, input logic [7:0] d1,
                       input logic [7:0] d2, input logic [7:0] d3);
    bus.valid = v;
    bus.in0   = d0;
    bus.in1   = d1;
    bus.in2   = d2;
    bus.in3   = d3;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_byte(input string tag, input logic [7:0] d, input logic [3:0] p);
    chk({tag, " validout"}, 32'(bus.validout), 32'd1);
    chk({tag, " out"}, 32'(bus.out), 32'(d));
    chk({tag, " pop"}, 32'(bus.pop), 32'(p));
  endtask

  task automatic chk_none(input string tag);
    chk({tag, " validout"}, 32'(bus.validout), 32'd0);
    chk({tag, " pop"}, 32'(bus.pop), 32'd0);
  endtask

  logic [7:0] a_bytes [4];
  logic [7:0] b_bytes [8];

  initial begin
    n_tests = 0;
    n_fail  = 0;
    a_bytes = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    b_bytes = '{8'hB0, 8'hB1, 8'hB2, 8'hB3, 8'hB4, 8'hB5, 8'hB6, 8'hB7};
    reset = 1'b1;
    bus.lanes_active = 2'd2;
    bus.enable = 1'b0;
    drive(4'h0, 8'h00, 8'h00, 8'h00, 8'h00);
    step();
    step();

    // Reset state
    chk("rst out", 32'(bus.out), 32'd0);
    chk_none("rst");
    chk("rst full", 32'(bus.full), 32'd0);
    chk("rst overflow", 32'(bus.overflow), 32'd0);
    chk("rst idle", 32'(bus.idle), 32'd1);
    chk("rst state", 32'(bus.dbg_state), 32'd0);

    // x4 in-order merge
    reset = 1'b0;
    bus.enable = 1'b1;
    step();
    chk("run state", 32'(bus.dbg_state), 32'd1);
    drive(4'hF, 8'hA0, 8'hA1, 8'hA2, 8'hA3);
    step();
    drive(4'h0, 8'h00, 8'h00, 8'h00, 8'h00);
    chk_none("x4 latency");
    for (int i = 0; i < 4; i++) begin
      step();
      chk_byte("x4 byte", a_bytes[i], 4'(1 << i));
    end
    step();
    chk_none("x4 drained");
    bus.enable = 1'b0;
    step();
    chk("x4 idle", 32'(bus.idle), 32'd1);

    // Skew: lane2 lags by three cycles
    bus.enable = 1'b1;
    step();
    drive(4'b1011, 8'hC0, 8'hC1, 8'h00, 8'hC3);
    step();
    drive(4'h0, 8'h00, 8'h00, 8'h00, 8'h00);
    step();
    chk_byte("skew c0", 8'hC0, 4'h1);
    step();
    chk_byte("skew c1", 8'hC1, 4'h2);
    drive(4'b0100, 8'h00, 8'h00, 8'hC2, 8'h00);
    step();
    drive(4'h0, 8'h00, 8'h00, 8'h00, 8'h00);
    chk_none("skew wait");
    chk("skew out hold", 32'(bus.out), 32'hC1);
    step();
    chk_byte("skew c2", 8'hC2, 4'h4);
    step();
    chk_byte("skew c3", 8'hC3, 4'h8);
    step();
    chk_none("skew drained");

    // x2 mode with junk on lanes 2/3
    bus.enable = 1'b0;
    step();
    bus.lanes_active = 2'd1;
    bus.enable = 1'b1;
    step();
    for (int c = 0; c < 9; c++) begin
      if ((c % 2 == 0) && (c < 8))
        drive({1'b1, c[0] ? 1'b1 : 1'b0, 2'b11}, b_bytes[c], b_bytes[c + 1], 8'hEE, 8'hEE);
      else
        drive({1'b1, c[0] ? 1'b1 : 1'b0, 2'b00}, 8'h00, 8'h00, 8'hEE, 8'hEE);
      step();
      if (c >= 1) chk_byte("x2 byte", b_bytes[c - 1], ((c - 1) % 2 == 0) ? 4'h1 : 4'h2);
    end
    drive(4'h0, 8'h00, 8'h00, 8'h00, 8'h00);
    step();
    chk_none("x2 drained");
    chk("x2 overflow", 32'(bus.overflow), 32'd0);
    chk("x2 full", 32'(bus.full), 32'd0);

    // Overflow on lane0 while paused
    bus.enable = 1'b0;
    step();
    for (int j = 1; j <= 5; j++) begin
      drive(4'b0001, 8'(8'hD0 + j - 1), 8'h00, 8'h00, 8'h00);
      step();
      chk("ovf full", 32'(bus.full), (j >= 4) ? 32'd1 : 32'd0);
      chk("ovf overflow", 32'(bus.overflow), (j == 5) ? 32'd1 : 32'd0);
    end
    drive(4'h0, 8'h00, 8'h00, 8'h00, 8'h00);
    chk_none("ovf paused");
    bus.lanes_active = 2'd0;
    bus.enable = 1'b1;
    step();
    chk_none("ovf latch");
    for (int j = 0; j < 4; j++) begin
      step();
      chk_byte("ovf byte", 8'(8'hD0 + j), 4'h1);
    end
    step();
    chk_none("ovf drained");
    chk("ovf sticky", 32'(bus.overflow), 32'd1);
    chk("ovf full clr", 32'(bus.full), 32'd0);

    // Pause at ptr=2, resume with unchanged config
    bus.enable = 1'b0;
    step();
    bus.lanes_active = 2'd2;
    bus.enable = 1'b1;
    step();
    drive(4'hF, 8'hE0, 8'hE1, 8'hE2, 8'hE3);
    step();
    drive(4'h0, 8'h00, 8'h00, 8'h00, 8'h00);
    step();
    chk_byte("pause e0", 8'hE0, 4'h1);
    step();
    chk_byte("pause e1", 8'hE1, 4'h2);
    bus.enable = 1'b0;
    step();
    chk_none("pause off");
    chk("pause idle", 32'(bus.idle), 32'd0);
    chk("pause state", 32'(bus.dbg_state), 32'd0);
    bus.enable = 1'b1;
    step();
    chk_none("pause relatch");
    step();
    chk_byte("pause e2", 8'hE2, 4'h4);
    step();
    chk_byte("pause e3", 8'hE3, 4'h8);

    // Pause at ptr=2, resume as x1: ptr must restart at lane0
    drive(4'hF, 8'h60, 8'h61, 8'h62, 8'h63);
    step();
    drive(4'h0, 8'h00, 8'h00, 8'h00, 8'h00);
    step();
    chk_byte("cfg g0", 8'h60, 4'h1);
    step();
    chk_byte("cfg g1", 8'h61, 4'h2);
    bus.enable = 1'b0;
    step();
    chk_none("cfg off");
    bus.lanes_active = 2'd0;
    bus.enable = 1'b1;
    drive(4'b0001, 8'h70, 8'h00, 8'h00, 8'h00);
    step();
    drive(4'h0, 8'h00, 8'h00, 8'h00, 8'h00);
    step();
    chk_byte("cfg h0 lane0", 8'h70, 4'h1);
    step();
    chk_none("cfg x1 empty");

    // Reset with bytes buffered in every lane
    bus.enable = 1'b0;
    step();
    bus.lanes_active = 2'd2;
    bus.enable = 1'b1;
    step();
    bus.enable = 1'b0;
    for (int j = 0; j < 3; j++) begin
      drive(4'hF, 8'h80, 8'h81, 8'h82, 8'h83);
      step();
    end
    drive(4'h0, 8'h00, 8'h00, 8'h00, 8'h00);
    chk("prerst full", 32'(bus.full), 32'hC);
    chk("prerst overflow", 32'(bus.overflow), 32'd1);
    chk("prerst idle", 32'(bus.idle), 32'd0);
    reset = 1'b1;
    step();
    chk_none("flush");
    chk("flush out", 32'(bus.out), 32'd0);
    chk("flush full", 32'(bus.full), 32'd0);
    chk("flush overflow", 32'(bus.overflow), 32'd0);
    chk("flush idle", 32'(bus.idle), 32'd1);
    reset = 1'b0;
    bus.enable = 1'b1;
    step();
    step();
    chk_none("no stale 1");
    step();
    chk_none("no stale 2");
    drive(4'hF, 8'h90, 8'h91, 8'h92, 8'h93);
    step();
    drive(4'h0, 8'h00, 8'h00, 8'h00, 8'h00);
    step();
    chk_byte("post rst k0", 8'h90, 4'h1);
    step();
    chk_byte("post rst k1", 8'h91, 4'h2);

    // Final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
